rx_control_module: RTL and testbench

RX_CONTROL_MODULE -- requirements
Module: rx_control_module

---
 rtl/rx_control_module_pkg.sv | 15 +
 rtl/rx_control_module_baud.sv | 34 +++
 rtl/rx_control_module.sv | 105 ++++++++++
 tb/tb_rx_control_module.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rx_control_module_pkg.sv
// Shared UART definitions: controller state encoding and default bit timing.
// Used by the RX controller and intended for reuse by the TX controller.
package rx_control_module_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 50 MHz clock, 115200 baud.
    localparam int DEFAULT_BAUD_DIV = 434;

endpackage : rx_control_module_pkg

// File: rtl/rx_control_module_baud.sv
// Bit-period counter for the RX controller: counts 0..BAUD_DIV-1 while enabled
// and flags the mid-bit sample point and the last cycle of each bit period.
module rx_baud_counter #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic mid_tick,
    output logic end_tick
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == END_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign mid_tick = enable && (cnt == MID_CNT);
    assign end_tick = enable && (cnt == END_CNT);

endmodule : rx_baud_counter

// File: rtl/rx_control_module.sv
// UART receive controller: frames start/8 data/stop from an already synchronised
// line, presenting each good byte with a one-cycle rx_done or a frame_err pulse.
module rx_control_module
    import rx_control_module_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin_in,
    input  logic       h2l_sig,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    uart_state_t state, next_state;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        mid_tick, end_tick;
    logic        baud_clear, baud_enable;

    // Counter sits at 0 through IDLE, so the first START cycle is count 0.
    assign baud_clear  = (next_state == IDLE);
    assign baud_enable = (state != IDLE);

    rx_baud_counter #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .enable  (baud_enable),
        .mid_tick(mid_tick),
        .end_tick(end_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (h2l_sig && rx_en) next_state = START;
            end
            START: begin
                if (mid_tick && rx_pin_in) next_state = IDLE;
                else if (end_tick)         next_state = DATA;
            end
            DATA: begin
                if (end_tick && (bit_idx == 3'd7)) next_state = STOP;
            end
            STOP: begin
                if (mid_tick) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                START: begin
                    if (end_tick) bit_idx <= '0;
                end
                DATA: begin
                    if (mid_tick) shift_reg[bit_idx] <= rx_pin_in;
                    if (end_tick) bit_idx <= bit_idx + 1'b1;
                end
                STOP: begin
                    if (mid_tick) begin
                        if (rx_pin_in) begin
                            rx_data <= shift_reg;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule : rx_control_module

// File: tb/tb_rx_control_module.sv
// Directed bench for rx_control_module at BAUD_DIV=16: good frames, glitch,
// framing error, back-to-back frames, rx_en gating and mid-frame reset.
module tb_rx_control_module;

    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_pin_in;
    logic       h2l_sig;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int h2l_cyc      = 0;
    int done_cyc     = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int overlap_cnt  = 0;
    int d0, e0;

    rx_control_module #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_pin_in(rx_pin_in),
        .h2l_sig  (h2l_sig),
        .rx_en    (rx_en),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each output pulse.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        if (rx_done && frame_err) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame (start, 8 data LSB first, stop). Optional hooks drop
    // rx_en or pulse reset at a given frame cycle (negative disables).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int drop_en_at, input int reset_at);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10 * B; c++) begin
            @(negedge clk);
            rx_pin_in = bits[c / B];
            h2l_sig   = (c == 0);
            if (c == 0) h2l_cyc = cyc;
            if (c == drop_en_at) rx_en = 1'b0;
            if (reset_at >= 0 && c == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_busy",      busy,      1'b0);
                check("rst_mid_rx_data",   rx_data,   8'h00);
                check("rst_mid_rx_done",   rx_done,   1'b0);
                check("rst_mid_frame_err", frame_err, 1'b0);
            end
            if (reset_at >= 0 && c == reset_at + 2) rst_n = 1'b1;
        end
        @(negedge clk);
        rx_pin_in = 1'b1;
        h2l_sig   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_pin_in = 1'b1;
        h2l_sig   = 1'b0;
        rx_en     = 1'b1;
        idle_cycles(3);
        check("reset_busy",      busy,      1'b0);
        check("reset_rx_data",   rx_data,   8'h00);
        check("reset_rx_done",   rx_done,   1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        idle_cycles(3);

        // Good frame 0xA5; rx_done edge is 153 clocks after the edge sampling h2l_sig.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b1, -1, -1);
        idle_cycles(4);
        check("a5_done_cnt", done_cnt - d0, 1);
        check("a5_err_cnt",  err_cnt - e0,  0);
        check("a5_rx_data",  rx_data,       8'hA5);
        check("a5_latency",  done_cyc - h2l_cyc - 1, 153);
        check("a5_busy_end", busy,          1'b0);

        // Glitch: low for 4 cycles only; mid start bit sees high.
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk); rx_pin_in = 1'b0; h2l_sig = 1'b1;
        @(negedge clk); h2l_sig = 1'b0;
        check("glitch_busy_start", busy, 1'b1);
        idle_cycles(3); rx_pin_in = 1'b1;
        idle_cycles(6);
        check("glitch_busy_idle", busy, 1'b0);
        idle_cycles(20);
        check("glitch_done_cnt", done_cnt - d0, 0);
        check("glitch_err_cnt",  err_cnt - e0,  0);
        check("glitch_rx_data",  rx_data,       8'hA5);

        // Framing error on 0x3C.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1, -1);
        idle_cycles(4);
        check("ferr_err_cnt",  err_cnt - e0,  1);
        check("ferr_done_cnt", done_cnt - d0, 0);
        check("ferr_rx_data",  rx_data,       8'hA5);

        // Back-to-back 0x55 then 0xFF with no idle gap.
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, -1, -1);
        check("b2b_first_data", rx_data, 8'h55);
        send_frame(8'hFF, 1'b1, -1, -1);
        idle_cycles(4);
        check("b2b_done_cnt",    done_cnt - d0, 2);
        check("b2b_second_data", rx_data,       8'hFF);

        // rx_en low blocks a start.
        rx_en = 1'b0;
        @(negedge clk); h2l_sig = 1'b1;
        @(negedge clk); h2l_sig = 1'b0;
        check("en_off_busy", busy, 1'b0);
        idle_cycles(4);

        // rx_en dropped during DATA still completes 0x81.
        rx_en = 1'b1;
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 3 * B, -1);
        idle_cycles(4);
        check("en_drop_done_cnt", done_cnt - d0, 1);
        check("en_drop_rx_data",  rx_data,       8'h81);
        rx_en = 1'b1;

        // Reset asserted during data bit 4, then a fresh frame 0x12.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hC7, 1'b1, -1, 88);
        idle_cycles(20);
        check("rst_done_cnt", done_cnt - d0, 0);
        check("rst_err_cnt",  err_cnt - e0,  0);
        check("rst_busy",     busy,          1'b0);
        check("rst_rx_data",  rx_data,       8'h00);
        d0 = done_cnt;
        send_frame(8'h12, 1'b1, -1, -1);
        idle_cycles(4);
        check("post_rst_done_cnt", done_cnt - d0, 1);
        check("post_rst_rx_data",  rx_data,       8'h12);

        check("no_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rx_control_module
